// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter with packet lock in front of a UART transmitter
//
// Grants one of NREQ byte requesters to a single UART transmitter. While idle,
// the next requester is chosen round-robin, starting one past the last granted
// index. A byte with last=0 locks the transmitter to its requester until that
// requester sends a byte with last=1. Each byte is launched with a one-cycle
// tx_start once the transmitter is free. The transmitter must raise tx_busy
// within BUSY_TIMEOUT cycles, otherwise tx_timeout pulses and the arbiter
// returns to idle.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   req_valid  [NREQ]    requester i has a byte pending
//   req_data   [8*NREQ]  byte of requester i in bits [8i+7:8i]
//   req_last   [NREQ]    byte is the final one of requester i's packet
//   req_ready  [NREQ]    one-cycle pulse, byte of requester i accepted
//   grant      [NREQ]    one-hot owner of the transmitter, 0 when idle
//   tx_data    [8]       byte to the transmitter
//   tx_start   one-cycle start pulse to the transmitter
//   tx_busy    transmitter busy
//   tx_timeout one-cycle pulse, tx_busy never rose after tx_start
module uart_tx_arb #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              tx_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   rr_ptr, rr_ptr_d;
  logic [IW-1:0]   gidx, gidx_d;
  logic [IW-1:0]   lock_owner, lock_owner_d;
  logic            lock, lock_d;
  logic            last_q, last_d;
  logic [NREQ-1:0] req_ready_d, grant_d;
  logic [7:0]      tx_data_d;
  logic            tx_start_d, tx_timeout_d;
  logic            fin;
  logic            sel_found;
  logic [IW-1:0]   sel_idx, cand;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  // Candidate selection: the lock owner alone when locked, otherwise the
  // first valid requester scanning circularly from rr_ptr+1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    if (lock) begin
      sel_found = req_valid[lock_owner];
      sel_idx   = lock_owner;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        cand = wrap_idx(rr_ptr, off);
        if (!sel_found && req_valid[cand]) begin
          sel_found = 1'b1;
          sel_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    rr_ptr_d     = rr_ptr;
    gidx_d       = gidx;
    lock_d       = lock;
    lock_owner_d = lock_owner;
    last_d       = last_q;
    req_ready_d  = '0;
    grant_d      = grant;
    tx_data_d    = tx_data;
    tx_start_d   = 1'b0;
    tx_timeout_d = 1'b0;
    fin          = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          tx_data_d   = req_data[{sel_idx, 3'b000} +: 8];
          grant_d     = NREQ'(1) << sel_idx;
          req_ready_d = NREQ'(1) << sel_idx;
          gidx_d      = sel_idx;
          last_d      = req_last[sel_idx];
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        // A transmitter still busy with a previous byte holds the launch.
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          tx_timeout_d = 1'b1;
          fin          = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) fin = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Byte finished (or abandoned on timeout): release the transmitter and
    // update round-robin pointer and packet lock from the granted byte.
    if (fin) begin
      state_d      = IDLE;
      grant_d      = '0;
      rr_ptr_d     = gidx;
      lock_d       = !last_q;
      lock_owner_d = gidx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= IW'(NREQ - 1);
      gidx       <= '0;
      lock       <= 1'b0;
      lock_owner <= '0;
      last_q     <= 1'b0;
      req_ready  <= '0;
      grant      <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      rr_ptr     <= rr_ptr_d;
      gidx       <= gidx_d;
      lock       <= lock_d;
      lock_owner <= lock_owner_d;
      last_q     <= last_d;
      req_ready  <= req_ready_d;
      grant      <= grant_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      tx_timeout <= tx_timeout_d;
    end
  end

endmodule
